pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V core. It takes hazard sources from the ID, EX and MEM stages and from the I/D caches. It drives per-register stall and flush enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also tracks the fixed-latency multiplier and wrong-path fetch kills, and keeps stall/flush performance counters.

Parameters:
MUL_LAT, 4, multiplier latency in cycles (legal range 2..15); a MUL in EX holds the front end for MUL_LAT-1 cycles.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
ex_rd  in  5  rd of the instruction in EX
ex_mem_ren  in  1  instruction in EX is a load
ex_mul  in  1  instruction in EX is a MUL
ex_mispredict  in  1  EX resolved a branch/jump whose destination differs from the predicted one
icache_stall  in  1  I-cache miss in progress
dcache_stall  in  1  D-cache miss in progress
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
stall_mem_wb  out  1  hold MEM/WB
flush_if_id  out  1  load NOP into IF/ID
flush_id_ex  out  1  load bubble into ID/EX (applied only when stall_id_ex=0)
flush_ex_mem  out  1  load bubble into EX/MEM
mul_busy  out  1  multiplier sequence active (state BUSY)
stall_cnt  out  CNT_W  cycles with stall_pc=1
flush_cnt  out  CNT_W  number of mispredict flushes taken

Behaviour:
- Outputs are combinational from state and inputs. Counters are registered, saturating at all-ones.
- While rst=1: state=IDLE, mul_cnt=0, kill_pending=0, counters=0, all outputs 0. Reset asserted mid-MUL or mid-kill aborts immediately.
- Hazard terms:
  - load_use = ex_mem_ren & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - mul_hold = (state==IDLE & ex_mul) | state==BUSY.
- Priority, highest first; a cycle's outputs come from the first matching rule:
  1. dcache_stall: all five stall_* = 1, all flushes 0.
  2. mul_hold: stall_pc, stall_if_id, stall_id_ex = 1; flush_ex_mem = 1.
  3. ex_mispredict: stall_* = 0; flush_if_id = 1, flush_id_ex = 1; flush_cnt++.
  4. load_use: stall_pc = 1, stall_if_id = 1; flush_id_ex = 1 (one bubble).
  5. icache_stall or kill_pending: stall_pc = 1; flush_if_id = 1.
  6. Otherwise: all outputs 0.
- Rule 5 outputs are also OR'd into rules 3 and 4. Under rule 3, stall_pc remains 0 so the redirect target still loads.
- MUL FSM (states IDLE, BUSY, DONE):
  - IDLE: when ex_mul=1 and dcache_stall=0, set mul_cnt=MUL_LAT-2 and go to BUSY.
  - BUSY: mul_cnt decrements every cycle, including during dcache_stall. When mul_cnt==0, go to DONE.
  - DONE: mul_hold=0, so the pipeline advances if dcache_stall=0. Go to IDLE on the first cycle with dcache_stall=0. While in DONE, ex_mul is ignored so the same MUL cannot retrigger.
  - Result: the front end stalls exactly MUL_LAT-1 cycles per MUL when no D-cache miss overlaps. Back-to-back MULs each pay the full latency.
- kill_pending:
  - Set when ex_mispredict=1, icache_stall=1 and rule 1 does not apply (the in-flight fetch is wrong-path).
  - Cleared on the first cycle with icache_stall=0; flush_if_id is still 1 in that cycle.
  - A new mispredict while pending keeps it set.
- ex_mispredict during dcache_stall or mul_hold is not acted on and not counted. EX is frozen, so it is re-evaluated on release.
- ex_mispredict and load_use are mutually exclusive by construction, since a branch has no rd load; if both occur, rule 3 wins.
- stall_cnt increments on every cycle where stall_pc=1.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - mul FSM state encoding (IDLE=0, BUSY=1, DONE=2);
  - NOP encoding 32'h0000_0013 used by flush_if_id consumers;
  - REG_X0 = 5'd0.
- One sub-module, mul_latency_tracker, owns the IDLE/BUSY/DONE FSM and mul_cnt.
  - Inputs: clk, rst, ex_mul, dcache_stall.
  - Outputs: mul_hold, mul_busy.
- Everything else stays in pipeline_hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_ren=1, ex_rd=5, id_rs2=5 for one cycle -> stall_pc=1, stall_if_id=1, flush_id_ex=1, stall_id_ex=0 that cycle only; with ex_rd=0 instead -> all outputs 0.
2. MUL, MUL_LAT=4: ex_mul held high -> stall_pc=1 and flush_ex_mem=1 for exactly 3 cycles, 0 on the 4th; mul_busy=1 for 2 cycles. A second MUL entering EX on the 5th cycle -> another 3 stall cycles.
3. Mispredict with icache_stall=1 for 3 cycles starting the same cycle -> flush_id_ex=1 for 1 cycle; flush_if_id=1 on all 4 cycles (through the icache_stall-falling cycle); stall_pc=0 on the mispredict cycle; flush_cnt=1.
4. dcache_stall=1 for 5 cycles overlapping load_use and ex_mispredict -> all five stall_*=1 and no flushes for those cycles; on release the mispredict is honoured once and flush_cnt increments by exactly 1.
5. MUL with dcache_stall=1 from cycle 1 to cycle 6 (MUL_LAT=4) -> FSM reaches DONE by cycle 3 and holds DONE through cycle 6; pipeline resumes at cycle 7 with no extra MUL stall.
6. rst=1 asserted in BUSY with kill_pending=1 -> next cycle state IDLE, kill_pending=0, stall_cnt=0, flush_cnt=0, all outputs 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the pipeline control blocks
package riscv_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard sources in, stall/flush controls and counters out
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_ren, ex_mul, ex_mispredict, icache_stall, dcache_stall;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mul_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_ren, ex_mul, ex_mispredict, icache_stall, dcache_stall,
    input stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
    input flush_if_id, flush_id_ex, flush_ex_mem, mul_busy, stall_cnt, flush_cnt
  );
  modport slave (
    input id_rs1, id_rs2, ex_rd, ex_mem_ren, ex_mul, ex_mispredict, icache_stall, dcache_stall,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
    output flush_if_id, flush_id_ex, flush_ex_mem, mul_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_mul.sv
// mul_latency_tracker: holds the front end while a fixed-latency MUL completes
module mul_latency_tracker
  import riscv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mul,
  input  logic dcache_stall,
  output logic mul_hold,
  output logic mul_busy
);
  mul_state_e state, state_nx;
  logic [3:0] mul_cnt, cnt_nx;
  // state and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_cnt <= '0;
    end else begin
      state <= state_nx;
      mul_cnt <= cnt_nx;
    end
  end
  // BUSY lasts MUL_LAT-2 cycles; DONE waits out any D-cache miss so the same MUL cannot retrigger
  always_comb begin
    state_nx = state;
    cnt_nx = mul_cnt;
    case (state)
      IDLE: if (ex_mul && !dcache_stall) begin
        state_nx = (MUL_LAT == 2) ? DONE : BUSY;
        cnt_nx = 4'(MUL_LAT - 2);
      end
      BUSY: begin
        cnt_nx = mul_cnt - 4'd1;
        state_nx = (mul_cnt <= 4'd1) ? DONE : BUSY;
      end
      DONE: state_nx = dcache_stall ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign mul_hold = !rst && ((state == IDLE && ex_mul) || state == BUSY);
  assign mul_busy = !rst && state == BUSY;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritised stall/flush sequencer with performance counters
module pipeline_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  logic load_use, mul_hold, mul_busy, kill_pending, front, misp_take;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  mul_latency_tracker #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk),
    .rst(rst),
    .ex_mul(hz.ex_mul),
    .dcache_stall(hz.dcache_stall),
    .mul_hold(mul_hold),
    .mul_busy(mul_busy)
  );
  assign load_use = hz.ex_mem_ren && hz.ex_rd != REG_X0 &&
                    (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
  assign front = hz.icache_stall || kill_pending;
  assign misp_take = !rst && !hz.dcache_stall && !mul_hold && hz.ex_mispredict;
  // first matching hazard wins; a pending fetch kill rides along with mispredict and load-use
  always_comb begin
    hz.stall_pc = 1'b0;
    hz.stall_if_id = 1'b0;
    hz.stall_id_ex = 1'b0;
    hz.stall_ex_mem = 1'b0;
    hz.stall_mem_wb = 1'b0;
    hz.flush_if_id = 1'b0;
    hz.flush_id_ex = 1'b0;
    hz.flush_ex_mem = 1'b0;
    if (rst) begin
    end else if (hz.dcache_stall) begin
      hz.stall_pc = 1'b1;
      hz.stall_if_id = 1'b1;
      hz.stall_id_ex = 1'b1;
      hz.stall_ex_mem = 1'b1;
      hz.stall_mem_wb = 1'b1;
    end else if (mul_hold) begin
      hz.stall_pc = 1'b1;
      hz.stall_if_id = 1'b1;
      hz.stall_id_ex = 1'b1;
      hz.flush_ex_mem = 1'b1;
    end else if (hz.ex_mispredict) begin
      hz.flush_if_id = 1'b1;
      hz.flush_id_ex = 1'b1;
    end else if (load_use) begin
      hz.stall_pc = 1'b1;
      hz.stall_if_id = 1'b1;
      hz.flush_id_ex = 1'b1;
      hz.flush_if_id = front;
    end else if (front) begin
      hz.stall_pc = 1'b1;
      hz.flush_if_id = 1'b1;
    end
  end
  // wrong-path fetch tracking and saturating stall/flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_pending <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      kill_pending <= hz.icache_stall && (misp_take || kill_pending);
      stall_cnt <= stall_cnt + CNT_W'(hz.stall_pc && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(misp_take && !(&flush_cnt));
    end
  end
  assign hz.mul_busy = mul_busy;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table plus multi-cycle sequences
module tb_pipeline_hazard_ctrl;
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic ren, mul, misp, ic, dc;
    logic [8:0] exp;
  } vec_t;
  localparam logic [8:0] Z = 9'b000000000;
  localparam logic [8:0] LU = 9'b110000100;
  localparam logic [8:0] LUIC = 9'b110001100;
  localparam logic [8:0] IC = 9'b100001000;
  localparam logic [8:0] DC = 9'b111110000;
  localparam logic [8:0] DB = 9'b111110001;
  localparam logic [8:0] MP = 9'b000001100;
  localparam logic [8:0] MH = 9'b111000010;
  localparam logic [8:0] MB = 9'b111000011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[14];
  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();
  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [4:0] rs1, rs2, rd, input logic ren, mul, misp, ic, dc,
                             input logic [8:0] exp);
    vec_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.ren = ren; r.mul = mul;
    r.misp = misp; r.ic = ic; r.dc = dc; r.exp = exp;
    return r;
  endfunction
  function automatic logic [8:0] outs();
    return {hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem, hz.stall_mem_wb,
            hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.mul_busy};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic apply(input vec_t x, input string nm);
    hz.id_rs1 = x.rs1; hz.id_rs2 = x.rs2; hz.ex_rd = x.rd;
    hz.ex_mem_ren = x.ren; hz.ex_mul = x.mul; hz.ex_mispredict = x.misp;
    hz.icache_stall = x.ic; hz.dcache_stall = x.dc;
    @(negedge clk);
    chk(nm, 32'(outs()), 32'(x.exp));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "reset_outs");
    rst = 1'b0;
  endtask
  initial begin
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, Z);
    tbl[1]  = v(1, 5, 5, 1, 0, 0, 0, 0, LU);
    tbl[2]  = v(0, 0, 0, 1, 0, 0, 0, 0, Z);
    tbl[3]  = v(7, 2, 7, 1, 0, 0, 0, 0, LU);
    tbl[4]  = v(3, 4, 7, 1, 0, 0, 0, 0, Z);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 1, 0, IC);
    tbl[6]  = v(9, 1, 9, 1, 0, 0, 1, 0, LUIC);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, 1, DC);
    tbl[8]  = v(6, 2, 6, 1, 0, 0, 1, 1, DC);
    tbl[9]  = v(5, 0, 5, 0, 0, 0, 0, 0, Z);
    tbl[10] = v(0, 0, 0, 0, 0, 1, 0, 0, MP);
    tbl[11] = v(8, 0, 8, 1, 0, 1, 0, 0, MP);
    tbl[12] = v(0, 0, 0, 0, 0, 1, 0, 1, DC);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 1, 0, IC);
    do_reset();
    @(negedge clk);
    chk("reset_stall_cnt", hz.stall_cnt, 0);
    chk("reset_flush_cnt", hz.flush_cnt, 0);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));
    // back-to-back MULs each stall the front end MUL_LAT-1 cycles
    do_reset();
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MH), "mul0_c0");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MB), "mul0_c1");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MB), "mul0_c2");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, Z), "mul0_done");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MH), "mul1_c0");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MB), "mul1_c1");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MB), "mul1_c2");
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, Z), "mul1_done");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "mul_idle");
    chk("mul_stall_cnt", hz.stall_cnt, 6);
    chk("mul_flush_cnt", hz.flush_cnt, 0);
    // mispredict under an I-cache miss kills the wrong-path fetch
    do_reset();
    apply(v(0, 0, 0, 0, 0, 1, 1, 0, MP), "kill_c0");
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, IC), "kill_c1");
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, IC), "kill_c2");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, IC), "kill_fall");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "kill_clear");
    chk("kill_flush_cnt", hz.flush_cnt, 1);
    chk("kill_stall_cnt", hz.stall_cnt, 3);
    // D-cache miss freezes everything, the mispredict is honoured once on release
    do_reset();
    for (int i = 0; i < 5; i++) apply(v(5, 0, 5, 1, 0, 1, 0, 1, DC), $sformatf("dc_c%0d", i));
    chk("dc_flush_cnt_held", hz.flush_cnt, 0);
    apply(v(5, 0, 5, 1, 0, 1, 0, 0, MP), "dc_release");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "dc_after");
    chk("dc_flush_cnt", hz.flush_cnt, 1);
    chk("dc_stall_cnt", hz.stall_cnt, 5);
    // MUL overlapped by a D-cache miss finishes in DONE with no extra stall
    do_reset();
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, MH), "mdc_c0");
    apply(v(0, 0, 0, 0, 1, 0, 0, 1, DB), "mdc_c1");
    apply(v(0, 0, 0, 0, 1, 0, 0, 1, DB), "mdc_c2");
    for (int i = 3; i <= 6; i++) apply(v(0, 0, 0, 0, 1, 0, 0, 1, DC), $sformatf("mdc_c%0d", i));
    apply(v(0, 0, 0, 0, 1, 0, 0, 0, Z), "mdc_c7");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "mdc_c8");
    // reset in BUSY with a pending kill aborts both
    do_reset();
    apply(v(0, 0, 0, 0, 0, 1, 1, 0, MP), "rst_kill");
    apply(v(0, 0, 0, 0, 1, 0, 1, 0, MH), "rst_mul");
    @(negedge clk);
    chk("rst_pre_flush_cnt", hz.flush_cnt, 1);
    rst = 1'b1;
    apply(v(0, 0, 0, 0, 1, 0, 1, 0, Z), "rst_busy");
    rst = 1'b0;
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, Z), "rst_after");
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    chk("rst_flush_cnt", hz.flush_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
